booth_dadda_mult: RTL and testbench

BOOTH_DADDA_MULT -- requirements
Module: booth_dadda_mult

---
 rtl/booth_dadda_mult.sv | 196 +++++++++++++++++++
 tb/tb_booth_dadda_mult.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/booth_dadda_mult.sv
// booth_dadda_mult
//   Two-stage unsigned 24x24 -> 48-bit multiplier.
//   Stage 1 registers the operands and the valid flag every cycle.
//   Stage 2 registers the product of the stage-1 operands. That product is formed by
//   radix-8 Booth recoding, a carry-save reduction tree and one final 48-bit adder.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset; clears every register
//   in_valid   x_in/y carry an operation this cycle
//   x_in       24-bit unsigned multiplicand
//   y          24-bit unsigned multiplier
//   out_valid  product carries a result this cycle
//   product    48-bit unsigned x_in*y, two cycles after sampling
//
// Handshake: valid-only, with no ready and no stall. An operation sampled with in_valid=1
// at edge N shows up with out_valid=1 after edge N+1. product is recomputed every cycle
// whatever the valid state, so consumers must qualify it with out_valid.
module booth_dadda_mult (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [23:0] x_in,
    input  logic [23:0] y,
    output logic        out_valid,
    output logic [47:0] product
);

    // ---------------- stage 1: operand capture ----------------
    logic [23:0] x_q;
    logic [23:0] y_q;
    logic        v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
            v_q <= 1'b0;
        end else begin
            x_q <= x_in;
            y_q <= y;
            v_q <= in_valid;
        end
    end

    // ---------------- multiples of x ----------------
    // 3x is the only multiple that is not a shift. It needs its own adder.
    logic [26:0] mul1, mul2, mul3, mul4;

    assign mul1 = {3'b000, x_q};
    assign mul2 = {2'b00, x_q, 1'b0};
    assign mul4 = {1'b0, x_q, 2'b00};
    assign mul3 = mul1 + mul2;

    // ---------------- radix-8 Booth recoding ----------------
    // Bit k+1 of y_ext is y[k]. Bit 0 is the implicit y[-1]=0.
    // The three zero bits on top make the last group non-negative.
    logic [27:0] y_ext;
    assign y_ext = {3'b000, y_q, 1'b0};

    // Encoder output is {neg, |d|=4, |d|=3, |d|=2, |d|=1}, where
    // d = -4*g[3] + 2*g[2] + g[1] + g[0].
    function automatic logic [4:0] booth_enc(input logic [3:0] g);
        logic [4:0] e;
        e = 5'b00000;
        unique case (g)
            4'b0000: e = 5'b00000;  //  0
            4'b0001: e = 5'b00001;  // +1
            4'b0010: e = 5'b00001;  // +1
            4'b0011: e = 5'b00010;  // +2
            4'b0100: e = 5'b00010;  // +2
            4'b0101: e = 5'b00100;  // +3
            4'b0110: e = 5'b00100;  // +3
            4'b0111: e = 5'b01000;  // +4
            4'b1000: e = 5'b11000;  // -4
            4'b1001: e = 5'b10100;  // -3
            4'b1010: e = 5'b10100;  // -3
            4'b1011: e = 5'b10010;  // -2
            4'b1100: e = 5'b10010;  // -2
            4'b1101: e = 5'b10001;  // -1
            4'b1110: e = 5'b10001;  // -1
            4'b1111: e = 5'b00000;  //  0
            default: e = 5'b00000;
        endcase
        return e;
    endfunction

    // The magnitude selects are one-hot, so an AND-OR mux is enough.
    // For negative digits the row holds ~mag. The +1 that completes the negation
    // comes in separately as a neg bit.
    function automatic logic [26:0] booth_sel(input logic [4:0]  e,
                                               input logic [26:0] m1,
                                               input logic [26:0] m2,
                                               input logic [26:0] m3,
                                               input logic [26:0] m4);
        logic [26:0] mag;
        mag = ({27{e[0]}} & m1) | ({27{e[1]}} & m2) |
              ({27{e[2]}} & m3) | ({27{e[3]}} & m4);
        return mag ^ {27{e[4]}};
    endfunction

    logic [4:0]  enc [9];
    logic [26:0] pp  [9];

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            enc[i] = booth_enc(y_ext[3*i +: 4]);
            pp[i]  = booth_sel(enc[i], mul1, mul2, mul3, mul4);
        end
    end

    // ---------------- partial-product rows ----------------
    // Each row is a 28-bit two's-complement value {neg, pp} at weight 8^i.
    // Sign extension is avoided by storing ~neg in place of the sign and adding the
    // constant -sum(2^(27+3i)) mod 2^48. That constant has bits 27,28,29 and then
    // the pairs (3i+28, 3i+29) for i >= 1.
    //   Row 0 folds its constant bit 27 into the inverted sign. With S = neg, the
    //   result is {~S, S, S, S} at relative bits 30..27.
    //   Row i >= 1 places {1, 1, ~S} at relative bits 29..27.
    // Everything at weight 2^48 or above is dropped.
    // neg_i goes into row i+1 at bit 3i, which that row leaves empty, so the tree
    // stays at 9 rows. Group 8 only ever sees {0,0,0,y[23]}, so its digit is 0 or +1
    // and it never needs a +1 of its own.
    logic [47:0] rows [9];

    always_comb begin : build_rows
        logic [32:0] ext;
        logic [56:0] wide;
        ext  = '0;
        wide = '0;
        for (int i = 0; i < 9; i++) begin
            if (i == 0) begin
                ext = {2'b00, ~enc[i][4], {3{enc[i][4]}}, pp[i]};
            end else begin
                ext = {3'b000, 2'b11, ~enc[i][4], pp[i]};
            end
            wide    = {24'b0, ext} << (3 * i);
            rows[i] = wide[47:0];
        end
        for (int i = 1; i < 9; i++) begin
            rows[i][3*i-3] = enc[i-1][4];
        end
    end

    // ---------------- reduction tree 9 -> 6 -> 4 -> 3 -> 2 ----------------
    // Each layer is a row of full adders. Positions where one input is known zero
    // reduce to half adders. A carry out of bit 47 has weight 2^48 and is dropped.
    function automatic logic [47:0] fa_sum(input logic [47:0] a,
                                           input logic [47:0] b,
                                           input logic [47:0] c);
        return a ^ b ^ c;
    endfunction

    function automatic logic [47:0] fa_carry(input logic [47:0] a,
                                             input logic [47:0] b,
                                             input logic [47:0] c);
        logic [47:0] maj;
        maj = (a & b) | (a & c) | (b & c);
        return {maj[46:0], 1'b0};
    endfunction

    logic [47:0] lvl6 [6];
    logic [47:0] lvl4 [4];
    logic [47:0] lvl3 [3];
    logic [47:0] lvl2 [2];
    logic [47:0] mult_result;

    always_comb begin
        for (int j = 0; j < 3; j++) begin
            lvl6[2*j]   = fa_sum  (rows[3*j], rows[3*j+1], rows[3*j+2]);
            lvl6[2*j+1] = fa_carry(rows[3*j], rows[3*j+1], rows[3*j+2]);
        end
        lvl4[0] = fa_sum  (lvl6[0], lvl6[1], lvl6[2]);
        lvl4[1] = fa_carry(lvl6[0], lvl6[1], lvl6[2]);
        lvl4[2] = fa_sum  (lvl6[3], lvl6[4], lvl6[5]);
        lvl4[3] = fa_carry(lvl6[3], lvl6[4], lvl6[5]);
        lvl3[0] = fa_sum  (lvl4[0], lvl4[1], lvl4[2]);
        lvl3[1] = fa_carry(lvl4[0], lvl4[1], lvl4[2]);
        lvl3[2] = lvl4[3];
        lvl2[0] = fa_sum  (lvl3[0], lvl3[1], lvl3[2]);
        lvl2[1] = fa_carry(lvl3[0], lvl3[1], lvl3[2]);
        mult_result = lvl2[0] + lvl2[1];
    end

    // ---------------- stage 2: result register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product   <= 48'h0;
            out_valid <= 1'b0;
        end else begin
            product   <= mult_result;
            out_valid <= v_q;
        end
    end

endmodule

// File: tb/tb_booth_dadda_mult.sv
// tb_booth_dadda_mult
//   Self-checking bench for booth_dadda_mult.
//   Expected results are (valid, x*y) pairs computed with plain 48-bit arithmetic
//   or taken as literal constants. They are queued in drive order. With the
//   two-cycle latency, the head of the queue is the result the outputs must show
//   at each falling edge.
module tb_booth_dadda_mult;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [23:0] x_in;
    logic [23:0] y;
    logic        out_valid;
    logic [47:0] product;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    booth_dadda_mult dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x_in      (x_in),
        .y         (y),
        .out_valid (out_valid),
        .product   (product)
    );

    // ---------------- scoreboard ----------------
    logic [48:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %012h expected %012h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [47:0] ref_prod(input logic [23:0] a, input logic [23:0] b);
        logic [47:0] wa, wb;
        wa = {24'h0, a};
        wb = {24'h0, b};
        return wa * wb;
    endfunction

    function automatic logic [23:0] rnd24();
        logic [23:0] r;
        case ($urandom_range(0, 7))
            0:       r = 24'h000000;
            1:       r = 24'hFFFFFF;
            2:       r = 24'h000001 << $urandom_range(0, 23);
            default: r = 24'($urandom);
        endcase
        return r;
    endfunction

    // ---------------- driver ----------------
    // At each falling edge, check the outputs against the oldest expectation, then
    // apply the next input and queue its expected result.
    task automatic step(input logic v, input logic [23:0] a, input logic [23:0] b,
                        input logic [47:0] e);
        logic [48:0] front;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 48'h1, 48'h0);
        end else begin
            front = exp_q.pop_front();
            check("out_valid", {47'h0, out_valid}, {47'h0, front[48]});
            check("product", product, front[47:0]);
        end
        exp_q.push_back({v, e});
        in_valid = v;
        x_in     = a;
        y        = b;
    endtask

    task automatic step_model(input logic v, input logic [23:0] a, input logic [23:0] b);
        step(v, a, b, ref_prod(a, b));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 24'h0, 24'h0, 48'h0);
    endtask

    // Registers are zero during reset, so the first two results after release are zeros.
    task automatic restart_scoreboard();
        exp_q.delete();
        exp_q.push_back(49'h0);
        exp_q.push_back(49'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        x_in     = 24'h0;
        y        = 24'h0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_product", product, 48'h0);
        check("reset_out_valid", {47'h0, out_valid}, 48'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        restart_scoreboard();

        // Directed values, driven back-to-back.
        step(1'b1, 24'hFFFFFF, 24'h000001, 48'h000000FFFFFF);
        step(1'b1, 24'hFFFFFF, 24'h000002, 48'h000001FFFFFE);
        step(1'b1, 24'hFFFFFF, 24'h000003, 48'h000002FFFFFD);
        step(1'b1, 24'hFFFFFF, 24'h000004, 48'h000003FFFFFC);
        step(1'b1, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
        step(1'b1, 24'h012345, 24'h067890, 48'h00075CCA2ED0);
        step_model(1'b1, 24'h14FEAC, 24'h8B4CFE);
        step(1'b1, 24'h000000, 24'hABCDEF, 48'h0);
        step(1'b1, 24'h123456, 24'h000000, 48'h0);
        idle(2);

        // Four consecutive operations, isolated by idle cycles.
        step_model(1'b1, 24'h000007, 24'h924924);
        step_model(1'b1, 24'h800000, 24'h800000);
        step_model(1'b1, 24'hAAAAAA, 24'h555555);
        step_model(1'b1, 24'h3C3C3C, 24'hDB6DB6);
        idle(3);

        // product follows the operands even with in_valid low.
        step_model(1'b0, 24'h00FF00, 24'h0F0F0F);
        step_model(1'b0, 24'hFFFFFF, 24'h7FFFFF);
        idle(2);

        // Reset while two operations are in flight.
        step_model(1'b1, 24'h111111, 24'h222222);
        step_model(1'b1, 24'h333333, 24'h444444);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_product", product, 48'h0);
        check("midreset_out_valid", {47'h0, out_valid}, 48'h0);
        in_valid = 1'b0;
        x_in     = 24'h0;
        y        = 24'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        restart_scoreboard();
        idle(4);

        // Random operands: continuous valid first, then with random gaps.
        for (int k = 0; k < 20000; k++) step_model(1'b1, rnd24(), rnd24());
        for (int k = 0; k < 20000; k++) step_model(1'($urandom_range(0, 1)), rnd24(), rnd24());
        idle(3);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
